// File: rtl/rgb_region_checksum_pkg.sv
// Shared definitions for the SRAM-side processing chain: state encodings,
// RGB region geometry and CRC constants.
package project_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_M1,
    S_CHECK
  } top_state_type;

  typedef enum logic [1:0] {
    S_CK_IDLE,
    S_CK_ISSUE,
    S_CK_DRAIN,
    S_CK_DONE
  } ck_state_type;

  localparam logic [17:0] RGB_BASE_ADDR  = 18'h23E00;
  localparam int          RGB_WORD_COUNT = 115200;
  localparam int          SRAM_RD_LAT    = 2;
  localparam logic [15:0] CRC16_POLY     = 16'h1021;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;

endpackage

// File: rtl/rgb_region_checksum_crc16_word_step.sv
// One 16-bit word of CRC-16/CCITT-FALSE: 16 bit-serial steps, MSB first,
// unrolled into a single combinational stage.
module crc16_word_step
  import project_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [15:0] data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/rgb_region_checksum.sv
// Streams the RGB display region back out of SRAM and folds every word into
// a modulo-2^16 sum and a CRC-16/CCITT-FALSE for on-board golden checking.
module rgb_region_checksum
  import project_pkg::*;
#(
  parameter logic [17:0] BASE_ADDRESS = RGB_BASE_ADDR,
  parameter int          WORD_COUNT   = RGB_WORD_COUNT,
  parameter int          READ_LATENCY = SRAM_RD_LAT,
  parameter logic [15:0] CRC_INIT     = CRC16_INIT
)(
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        start,
  input  logic [15:0] SRAM_read_data,
  input  logic [15:0] expected_crc,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic [15:0] SRAM_write_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic [15:0] crc,
  output logic        match
);

  localparam int CW = $clog2(WORD_COUNT + 1);

  ck_state_type            state, state_n;
  logic [CW-1:0]           issue_cnt;
  logic [READ_LATENCY-1:0] vld_pipe;
  logic                    done_seen;
  logic                    match_q;
  logic                    vld_tail;
  logic                    last_issue;
  logic                    drain_last;
  logic [15:0]             crc_next;

  assign SRAM_we_n       = 1'b1;
  assign SRAM_write_data = 16'h0000;
  assign busy            = (state == S_CK_ISSUE) || (state == S_CK_DRAIN);
  assign vld_tail        = vld_pipe[READ_LATENCY-1];
  assign last_issue      = (issue_cnt == CW'(WORD_COUNT - 1));
  assign match           = match_q & done_seen;

  // Drain ends on the cycle whose shift leaves the pipe empty: only the tail may still be set.
  always_comb begin
    drain_last = 1'b1;
    for (int i = 0; i < READ_LATENCY - 1; i++)
      if (vld_pipe[i]) drain_last = 1'b0;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_CK_IDLE:  if (start)      state_n = S_CK_ISSUE;
      S_CK_ISSUE: if (last_issue) state_n = S_CK_DRAIN;
      S_CK_DRAIN: if (drain_last) state_n = S_CK_DONE;
      S_CK_DONE:                  state_n = S_CK_IDLE;
      default:                    state_n = S_CK_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) state <= S_CK_IDLE;
    else         state <= state_n;
  end

  crc16_word_step u_crc (
    .crc_in  (crc),
    .data    (SRAM_read_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      SRAM_address <= BASE_ADDRESS;
      issue_cnt    <= '0;
      vld_pipe     <= '0;
      done         <= 1'b0;
      done_seen    <= 1'b0;
      match_q      <= 1'b0;
      sum          <= 16'h0000;
      crc          <= CRC_INIT;
    end else begin
      done        <= 1'b0;
      vld_pipe[0] <= (state == S_CK_ISSUE);
      for (int i = 1; i < READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      // Tail marks the word issued READ_LATENCY cycles ago arriving on the bus now.
      if (vld_tail) begin
        sum <= sum + SRAM_read_data;
        crc <= crc_next;
      end
      unique case (state)
        S_CK_IDLE: if (start) begin
          sum          <= 16'h0000;
          crc          <= CRC_INIT;
          match_q      <= 1'b0;
          done_seen    <= 1'b0;
          issue_cnt    <= '0;
          SRAM_address <= BASE_ADDRESS;
        end
        S_CK_ISSUE: begin
          SRAM_address <= SRAM_address + 18'd1;
          issue_cnt    <= issue_cnt + 1'b1;
        end
        S_CK_DONE: begin
          done      <= 1'b1;
          done_seen <= 1'b1;
          match_q   <= (crc == expected_crc);
        end
        default: ;
      endcase
    end
  end

endmodule
